// File: rtl/jk_excite_driver_if.sv
// Handshake and feedback bundle between the stimulus side and jk_excite_driver.
// The master is the upstream/jk_ff side; the slave is the driver itself.
interface jk_excite_driver_if #(
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_bit;
    logic             in_ready;
    logic             j;
    logic             k;
    logic             q_fb;
    logic             chk_valid;
    logic             err;
    logic [CNT_W-1:0] err_cnt;
    logic             busy;

    modport master (
        output in_valid, in_bit, q_fb,
        input  in_ready, j, k, chk_valid, err, err_cnt, busy
    );

    modport slave (
        input  in_valid, in_bit, q_fb,
        output in_ready, j, k, chk_valid, err, err_cnt, busy
    );
endinterface

// File: rtl/jk_excite_driver.sv
// Buffers target bits, drives J/K excitation toward each target, and checks q two edges later.
// Optional feature: define JK_STOP_ON_ERR_EN to freeze the stream (HALT) on the first mismatch.
module jk_excite_driver #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input logic               clk_i,
    input logic               rst_ni,
    jk_excite_driver_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

`ifdef JK_STOP_ON_ERR_EN
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_HALT = 2'd2} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1} state_t;
`endif

    state_t           state_q;
    state_t           state_d;
    logic             mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             q_pred_q;
    logic             j_q;
    logic             k_q;
    logic             exp_s1_q;
    logic             v_s1_q;
    logic             exp_s2_q;
    logic             v_s2_q;
    logic             chk_valid_q;
    logic             err_q;
    logic [CNT_W-1:0] err_cnt_q;

    logic             empty_s;
    logic             full_s;
    logic             push_s;
    logic             pop_s;
    logic             in_ready_s;
    logic             head_s;
    logic             mismatch_s;
    logic             last_pop_s;
    logic [AW:0]      occ_s;

    // Extra pointer bit distinguishes full from empty when the index bits match.
    assign empty_s    = (wr_ptr_q == rd_ptr_q);
    assign full_s     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign occ_s      = wr_ptr_q - rd_ptr_q;
    assign head_s     = mem_q[rd_ptr_q[AW-1:0]];
    assign push_s     = bus.in_valid && in_ready_s;
    assign mismatch_s = v_s2_q && (bus.q_fb != exp_s2_q);
    assign last_pop_s = pop_s && !push_s && (occ_s == {{AW{1'b0}}, 1'b1});

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: RUN tracks a non-empty FIFO so the first pop follows the push directly.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
`ifdef JK_STOP_ON_ERR_EN
                if (mismatch_s) begin
                    state_d = ST_HALT;
                end else
`endif
                if (push_s) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
`ifdef JK_STOP_ON_ERR_EN
                if (mismatch_s) begin
                    state_d = ST_HALT;
                end else
`endif
                if (last_pop_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RUN;
                end
            end
`ifdef JK_STOP_ON_ERR_EN
            ST_HALT: begin
                state_d = ST_HALT;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: pop permission and upstream backpressure.
    always_comb begin
        pop_s      = 1'b0;
        in_ready_s = !full_s;
        case (state_q)
            ST_RUN: begin
                pop_s = !empty_s;
            end
`ifdef JK_STOP_ON_ERR_EN
            ST_HALT: begin
                in_ready_s = 1'b0;
            end
`endif
            default: begin
                pop_s = 1'b0;
            end
        endcase
    end

    // Target FIFO storage and pointers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 1'b0;
            end
            wr_ptr_q <= {(AW + 1){1'b0}};
            rd_ptr_q <= {(AW + 1){1'b0}};
        end else begin
            if (push_s) begin
                mem_q[wr_ptr_q[AW-1:0]] <= bus.in_bit;
                wr_ptr_q                <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Excitation from the predicted state, plus the two-stage check pipeline.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_pred_q <= 1'b0;
            j_q      <= 1'b0;
            k_q      <= 1'b0;
            exp_s1_q <= 1'b0;
            v_s1_q   <= 1'b0;
            exp_s2_q <= 1'b0;
            v_s2_q   <= 1'b0;
        end else begin
            if (pop_s) begin
                q_pred_q <= head_s;
                j_q      <= !q_pred_q && head_s;
                k_q      <= q_pred_q && !head_s;
                exp_s1_q <= head_s;
                v_s1_q   <= 1'b1;
            end else begin
                j_q      <= 1'b0;
                k_q      <= 1'b0;
                v_s1_q   <= 1'b0;
            end
            exp_s2_q <= exp_s1_q;
            v_s2_q   <= v_s1_q;
        end
    end

    // Compare result: pulse, sticky flag and saturating counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            chk_valid_q <= 1'b0;
            err_q       <= 1'b0;
            err_cnt_q   <= {CNT_W{1'b0}};
        end else begin
            chk_valid_q <= v_s2_q;
            if (mismatch_s) begin
                err_q <= 1'b1;
                if (err_cnt_q != {CNT_W{1'b1}}) begin
                    err_cnt_q <= err_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.j         = j_q;
    assign bus.k         = k_q;
    assign bus.chk_valid = chk_valid_q;
    assign bus.err       = err_q;
    assign bus.err_cnt   = err_cnt_q;
    assign bus.busy      = !empty_s || v_s1_q || v_s2_q;
endmodule
